// File: rtl/ar_shifter.sv
// ---------------------------------------------------------------------------
// ar_shifter
//
// Accumulator register with a serial multi-bit shifter. Words hold WIDTH
// bits. Bit 0 is the MSB and the sign bit. A LOAD captures the ALU result.
// A SHIFT starts a sequence of COUNT single-bit shifts, one per clock.
// CLEAR zeroes the register and cancels any sequence in progress.
//
// Ports
//   clk     : clock; all state changes on its rising edge
//   CROBAR  : synchronous active-high reset
//   AD      : [0:WIDTH-1] adder result from the ALU slice chain
//   AD_CRY  : carry out of the most significant ALU slice
//   OP      : [0:1] command: 00 HOLD, 01 LOAD, 10 SHIFT, 11 CLEAR
//   DIR     : shift direction: 0 left (toward bit 0), 1 right
//   ARITH   : right-shift fill: 1 sign fill, 0 zero fill
//   COUNT   : [0:5] shift count, 0..63 (no clamping to WIDTH)
//   AR      : [0:WIDTH-1] register contents
//   LINK    : latched carry, or the last bit shifted out
//   BUSY    : high while a shift sequence runs
//   DONE    : one-cycle pulse after the final shift of a sequence
// ---------------------------------------------------------------------------
module ar_shifter #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             CROBAR,
    input  logic [0:WIDTH-1] AD,
    input  logic             AD_CRY,
    input  logic [0:1]       OP,
    input  logic             DIR,
    input  logic             ARITH,
    input  logic [0:5]       COUNT,
    output logic [0:WIDTH-1] AR,
    output logic             LINK,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [0:WIDTH-1] ar_q, ar_d;
    logic             link_q, link_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             arith_q, arith_d;

    // One-bit shifted copies of the register. They are built per bit so the
    // end cells (the zero fill on the left and the sign/zero fill on the
    // right) are explicit.
    logic [0:WIDTH-1] shl;
    logic [0:WIDTH-1] shr;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_shl_end
                assign shl[gi] = 1'b0;
            end else begin : g_shl_mid
                assign shl[gi] = ar_q[gi+1];
            end
            if (gi == 0) begin : g_shr_end
                // Sign fill re-inserts the current sign bit.
                assign shr[gi] = arith_q & ar_q[0];
            end else begin : g_shr_mid
                assign shr[gi] = ar_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ar_d    = ar_q;
        link_d  = link_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        arith_d = arith_q;

        if (OP == OP_CLEAR) begin
            // Aborting goes straight to IDLE, so no DONE pulse is produced.
            ar_d    = '0;
            link_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    // Other commands and operand inputs are ignored here.
                    if (dir_q) begin
                        link_d = ar_q[WIDTH-1];
                        ar_d   = shr;
                    end else begin
                        link_d = ar_q[0];
                        ar_d   = shl;
                    end
                    cnt_d   = cnt_q - 6'd1;
                    state_d = (cnt_q == 6'd1) ? S_FIN : S_SHIFT;
                end
                default: begin
                    // IDLE and FIN accept commands in the same way. Accepting
                    // them in FIN gives back-to-back sequences.
                    state_d = S_IDLE;
                    case (OP)
                        OP_LOAD: begin
                            ar_d   = AD;
                            link_d = AD_CRY;
                        end
                        OP_SHIFT: begin
                            dir_d   = DIR;
                            arith_d = ARITH;
                            cnt_d   = COUNT;
                            state_d = (COUNT != 6'd0) ? S_SHIFT : S_FIN;
                        end
                        OP_HOLD: ;
                        default: ;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state_q <= S_IDLE;
            ar_q    <= '0;
            link_q  <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            link_q  <= link_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
        end
    end

    // Every output comes from a flop or is decoded from the state flops.
    assign AR   = ar_q;
    assign LINK = link_q;
    assign BUSY = (state_q == S_SHIFT);
    assign DONE = (state_q == S_FIN);

endmodule

// File: tb/tb_ar_shifter.sv
// ---------------------------------------------------------------------------
// tb_ar_shifter
//
// Self-checking bench for ar_shifter (WIDTH = 36).
// A per-cycle vector table is applied in a loop. Each vector's expected
// outputs are pushed to a scoreboard queue when the vector is driven. They
// are popped and compared one time unit after the next rising edge.
// Hand-written sequences check shift counts at and beyond the register
// width.
// ---------------------------------------------------------------------------
module tb_ar_shifter;

    localparam int W = 36;

    logic          clk = 1'b0;
    logic          CROBAR = 1'b1;
    logic [0:W-1]  AD = '0;
    logic          AD_CRY = 1'b0;
    logic [0:1]    OP = 2'b00;
    logic          DIR = 1'b0;
    logic          ARITH = 1'b0;
    logic [0:5]    COUNT = '0;
    logic [0:W-1]  AR;
    logic          LINK;
    logic          BUSY;
    logic          DONE;

    ar_shifter #(.WIDTH(W)) dut (
        .clk    (clk),
        .CROBAR (CROBAR),
        .AD     (AD),
        .AD_CRY (AD_CRY),
        .OP     (OP),
        .DIR    (DIR),
        .ARITH  (ARITH),
        .COUNT  (COUNT),
        .AR     (AR),
        .LINK   (LINK),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  op;
        logic        dir;
        logic        arith;
        logic [5:0]  cnt;
        logic [35:0] ad;
        logic        cry;
        logic [35:0] ar;
        logic        link;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] SHFT = 2'b10;
    localparam logic [1:0] CLR  = 2'b11;

    function automatic void add(input logic rst, input logic [1:0] op,
                                input logic dir, input logic arith,
                                input logic [5:0] cnt, input logic [35:0] ad,
                                input logic cry, input logic [35:0] ar,
                                input logic link, input logic busy,
                                input logic done);
        vec_t v;
        v.rst = rst;  v.op = op;     v.dir = dir;   v.arith = arith;
        v.cnt = cnt;  v.ad = ad;     v.cry = cry;   v.ar = ar;
        v.link = link; v.busy = busy; v.done = done;
        tbl.push_back(v);
    endfunction

    // Drive one cycle's inputs, push its expectation, then check after the edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        CROBAR = v.rst; OP = v.op; DIR = v.dir; ARITH = v.arith;
        COUNT = v.cnt;  AD = v.ad; AD_CRY = v.cry;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_vec++;
        if (AR !== e.ar || LINK !== e.link || BUSY !== e.busy || DONE !== e.done) begin
            n_err++;
            $display("FAIL %s: got AR=%o LINK=%b BUSY=%b DONE=%b, want AR=%o LINK=%b BUSY=%b DONE=%b",
                     tag, AR, LINK, BUSY, DONE, e.ar, e.link, e.busy, e.done);
        end else begin
            $display("ok   %s: op=%b AR=%o LINK=%b BUSY=%b DONE=%b",
                     tag, v.op, AR, LINK, BUSY, DONE);
        end
    endtask

    // Load a value, start a long sequence, count BUSY cycles until DONE.
    task automatic run_long(input logic [35:0] ad, input logic dir,
                            input logic arith, input logic [5:0] cnt,
                            input logic [35:0] exp_ar, input logic exp_link,
                            input string tag);
        vec_t v;
        int   nbusy;
        v.rst = 1'b0; v.op = LOAD; v.dir = 1'b0; v.arith = 1'b0; v.cnt = '0;
        v.ad = ad; v.cry = 1'b0; v.ar = ad; v.link = 1'b0; v.busy = 1'b0; v.done = 1'b0;
        apply(v, {tag, "/load"});
        v.op = SHFT; v.dir = dir; v.arith = arith; v.cnt = cnt; v.busy = 1'b1;
        apply(v, {tag, "/start"});
        nbusy = 1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            OP = HOLD; DIR = ~dir; ARITH = ~arith; COUNT = 6'd1;
            @(posedge clk);
            #1;
            if (BUSY) nbusy++;
            else break;
        end
        n_vec++;
        if (nbusy != int'(cnt) || DONE !== 1'b1 || AR !== exp_ar || LINK !== exp_link) begin
            n_err++;
            $display("FAIL %s: got busy_cycles=%0d DONE=%b AR=%o LINK=%b, want busy_cycles=%0d DONE=1 AR=%o LINK=%b",
                     tag, nbusy, DONE, AR, LINK, cnt, exp_ar, exp_link);
        end else begin
            $display("ok   %s: busy_cycles=%0d AR=%o LINK=%b", tag, nbusy, AR, LINK);
        end
    endtask

    localparam logic [35:0] ONES = '1;
    localparam logic [35:0] Z    = '0;

    initial begin
        //   rst op    dir  arith cnt    ad                cry   ar                link busy done
        // reset with LOAD of all ones pending
        add(1, LOAD, 0, 0, 6'd0,  ONES,             1, Z,                0, 0, 0);
        add(1, LOAD, 0, 0, 6'd0,  ONES,             1, Z,                0, 0, 0);
        // load and hold
        add(0, LOAD, 0, 0, 6'd0,  36'o123456701234, 1, 36'o123456701234, 1, 0, 0);
        add(0, HOLD, 0, 0, 6'd0,  Z,                0, 36'o123456701234, 1, 0, 0);
        // left shift by 3
        add(0, LOAD, 0, 0, 6'd0,  36'o400000000001, 0, 36'o400000000001, 0, 0, 0);
        add(0, SHFT, 0, 0, 6'd3,  Z,                0, 36'o400000000001, 0, 1, 0);
        add(0, HOLD, 0, 0, 6'd0,  Z,                0, 36'o000000000002, 1, 1, 0);
        add(0, HOLD, 0, 0, 6'd0,  Z,                0, 36'o000000000004, 0, 1, 0);
        add(0, HOLD, 0, 0, 6'd0,  Z,                0, 36'o000000000010, 0, 0, 1);
        add(0, HOLD, 0, 0, 6'd0,  Z,                0, 36'o000000000010, 0, 0, 0);
        // arithmetic right shift by 4
        add(0, LOAD, 0, 0, 6'd0,  36'o400000000000, 0, 36'o400000000000, 0, 0, 0);
        add(0, SHFT, 1, 1, 6'd4,  Z,                0, 36'o400000000000, 0, 1, 0);
        add(0, HOLD, 1, 1, 6'd0,  Z,                0, 36'o600000000000, 0, 1, 0);
        add(0, HOLD, 1, 1, 6'd0,  Z,                0, 36'o700000000000, 0, 1, 0);
        add(0, HOLD, 1, 1, 6'd0,  Z,                0, 36'o740000000000, 0, 1, 0);
        add(0, HOLD, 1, 1, 6'd0,  Z,                0, 36'o760000000000, 0, 0, 1);
        // LOAD accepted during FIN, then logical right shift by 4.
        // Mid-sequence LOAD/DIR/ARITH/COUNT changes must be ignored.
        add(0, LOAD, 0, 0, 6'd0,  36'o400000000000, 0, 36'o400000000000, 0, 0, 0);
        add(0, SHFT, 1, 0, 6'd4,  Z,                0, 36'o400000000000, 0, 1, 0);
        add(0, LOAD, 0, 1, 6'd7,  ONES,             1, 36'o200000000000, 0, 1, 0);
        add(0, SHFT, 0, 1, 6'd0,  ONES,             1, 36'o100000000000, 0, 1, 0);
        add(0, HOLD, 0, 1, 6'd2,  Z,                0, 36'o040000000000, 0, 1, 0);
        add(0, HOLD, 0, 0, 6'd0,  Z,                0, 36'o020000000000, 0, 0, 1);
        // zero count issued during FIN: DONE again, BUSY never high
        add(0, SHFT, 0, 0, 6'd0,  Z,                0, 36'o020000000000, 0, 0, 1);
        // back-to-back from FIN: left by 1
        add(0, SHFT, 0, 0, 6'd1,  Z,                0, 36'o020000000000, 0, 1, 0);
        add(0, HOLD, 0, 0, 6'd0,  Z,                0, 36'o040000000000, 0, 0, 1);
        add(0, SHFT, 1, 0, 6'd2,  Z,                0, 36'o040000000000, 0, 1, 0);
        add(0, HOLD, 0, 0, 6'd0,  Z,                0, 36'o020000000000, 0, 1, 0);
        add(0, HOLD, 0, 0, 6'd0,  Z,                0, 36'o010000000000, 0, 0, 1);
        add(0, HOLD, 0, 0, 6'd0,  Z,                0, 36'o010000000000, 0, 0, 0);
        // abort of a COUNT=10 sequence by CLEAR during the 4th BUSY cycle
        add(0, LOAD, 0, 0, 6'd0,  36'o777000000777, 1, 36'o777000000777, 1, 0, 0);
        add(0, SHFT, 0, 0, 6'd10, Z,                0, 36'o777000000777, 1, 1, 0);
        add(0, LOAD, 0, 0, 6'd0,  Z,                0, 36'o776000001776, 1, 1, 0);
        add(0, HOLD, 0, 0, 6'd0,  Z,                0, 36'o774000003774, 1, 1, 0);
        add(0, HOLD, 0, 0, 6'd0,  Z,                0, 36'o770000007770, 1, 1, 0);
        add(0, CLR,  0, 0, 6'd0,  Z,                0, Z,                0, 0, 0);
        add(0, HOLD, 0, 0, 6'd0,  Z,                0, Z,                0, 0, 0);
        add(0, HOLD, 0, 0, 6'd0,  Z,                0, Z,                0, 0, 0);
        // CROBAR mid-sequence, then a command on the first edge after it
        add(0, LOAD, 0, 0, 6'd0,  36'o000000000001, 0, 36'o000000000001, 0, 0, 0);
        add(0, SHFT, 1, 0, 6'd5,  Z,                0, 36'o000000000001, 0, 1, 0);
        add(0, HOLD, 1, 0, 6'd0,  Z,                0, Z,                1, 1, 0);
        add(1, HOLD, 0, 0, 6'd0,  Z,                0, Z,                0, 0, 0);
        add(0, SHFT, 0, 0, 6'd0,  Z,                0, Z,                0, 0, 1);
        add(0, HOLD, 0, 0, 6'd0,  Z,                0, Z,                0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // counts at and beyond the register width are honoured literally
        run_long(36'o400000000000, 1'b1, 1'b1, 6'd40, ONES, 1'b1, "asr40");
        run_long(ONES,             1'b0, 1'b0, 6'd36, Z,    1'b1, "shl36");
        run_long(ONES,             1'b0, 1'b0, 6'd63, Z,    1'b0, "shl63");
        run_long(ONES,             1'b1, 1'b0, 6'd37, Z,    1'b0, "lsr37");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ar_shifter.md
AR_SHIFTER -- requirements
Module: ar_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 36, the register width; bits are numbered [0:WIDTH-1] with bit 0 as MSB/sign.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port CROBAR, input, 1, the reset; it is synchronous and active-high.
REQ-004 SHALL have port AD, input, [0:WIDTH-1], the adder result from the upstream ALU slice chain.
REQ-005 SHALL have port AD_CRY, input, 1, the carry out of the most significant ALU slice.
REQ-006 SHALL have port OP, input, [0:1], the command: 00 HOLD, 01 LOAD, 10 SHIFT, 11 CLEAR.
REQ-007 SHALL have port DIR, input, 1, the shift direction: 0 left (toward bit 0), 1 right.
REQ-008 SHALL have port ARITH, input, 1, the right-shift fill select: 1 sign fill, 0 zero fill.
REQ-009 SHALL have port COUNT, input, [0:5], the shift count, 0..63.
REQ-010 SHALL have port AR, output, [0:WIDTH-1], the register contents.
REQ-011 SHALL have port LINK, output, 1, the latched carry or last bit shifted out.
REQ-012 SHALL have port BUSY, output, 1, high while a shift sequence is in progress.
REQ-013 SHALL have port DONE, output, 1, a one-cycle pulse marking completion of a shift sequence.

Function
REQ-014 SHALL implement states IDLE, SHIFT and FIN; BUSY = (state==SHIFT); DONE = (state==FIN).
REQ-015 In IDLE or FIN, OP=HOLD: AR and LINK SHALL hold; next state SHALL be IDLE.
REQ-016 In IDLE or FIN, OP=LOAD: AR<=AD and LINK<=AD_CRY at the edge; next state SHALL be IDLE.
REQ-017 In IDLE or FIN, OP=SHIFT: the block SHALL latch DIR, ARITH and COUNT into an internal counter; next state SHALL be SHIFT if COUNT!=0, else FIN with AR and LINK unchanged.
REQ-018 In SHIFT, each edge SHALL perform exactly one 1-bit shift and decrement the counter; when the counter was 1 at that edge, next state SHALL be FIN, else SHIFT.
REQ-019 Left shift: LINK<=AR[0]; AR<={AR[1:WIDTH-1],0}.
REQ-020 Right shift: LINK<=AR[WIDTH-1]; AR<={fill,AR[0:WIDTH-2]}, where fill = latched ARITH ? AR[0] : 0.
REQ-021 Latency: a SHIFT with COUNT=n>0 sampled at edge E0 SHALL give BUSY high for exactly n cycles (E0..En) and DONE high for exactly the one cycle after En; COUNT=0 SHALL give DONE the cycle after E0 with BUSY never high.
REQ-022 COUNT>=WIDTH SHALL be honoured literally: n shifts, with no clamping and no wrap.
REQ-023 While in SHIFT, OP values HOLD, LOAD and SHIFT SHALL be ignored, and changes on DIR, ARITH, COUNT and AD SHALL have no effect.
REQ-024 OP=CLEAR in any state SHALL set AR<=0 and LINK<=0 with next state IDLE; an aborted sequence SHALL NOT pulse DONE.
REQ-025 A SHIFT or LOAD command presented during the FIN cycle SHALL be accepted (back-to-back operation); DONE SHALL still be high for that cycle.
REQ-026 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-027 When CROBAR=1 at an edge, it SHALL override OP and all state: AR=0, LINK=0, state=IDLE, BUSY=0, DONE=0, counter=0.
REQ-028 Asserting CROBAR mid-sequence SHALL abort the sequence without a DONE pulse; the first command SHALL be accepted on the first edge after CROBAR deasserts.

Verification
REQ-029 Reset: CROBAR=1 for 2 cycles with OP=01, AD all ones -> AR=0, LINK=0, BUSY=0, DONE=0.
REQ-030 Load: OP=01, AD=0o123456701234, AD_CRY=1 -> next cycle AR=0o123456701234, LINK=1, BUSY=0.
REQ-031 Left shift: AR=0o400000000001, OP=10, DIR=0, COUNT=3 -> BUSY for 3 cycles, DONE for 1 cycle, then AR=0o000000000010, LINK=0; intermediate AR values 0o2, 0o4, 0o10 with LINK 1, 0, 0.
REQ-032 Arithmetic right shift: AR=0o400000000000, OP=10, DIR=1, ARITH=1, COUNT=4 -> final AR=0o760000000000, LINK=0; the same with ARITH=0 -> final AR=0o020000000000.
REQ-033 Zero count and back-to-back: COUNT=0 -> DONE the next cycle, BUSY never high, AR unchanged; OP=10 issued during DONE -> a new sequence starts with no idle cycle.
REQ-034 Abort: COUNT=10 and OP=11 asserted at the 4th BUSY cycle -> next cycle AR=0, LINK=0, BUSY=0, with no DONE pulse ever; OP=01 issued while BUSY is ignored.
